// File: rtl/imm_extend_stage.sv
// MIPS immediate-extension stage with a 2-entry (main + skid) valid/ready buffer.
// Optional feature macro: IMM_ZERO_EXTEND_EN (zero-extend andi/ori/xori immediates).
module imm_extend_stage #(
   parameter int unsigned TAG_W = 5
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [31:0]      Instruction,
   input  logic [TAG_W-1:0] InTag,
   input  logic             Flush,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [31:0]      ImmOut,
   output logic [1:0]       ExtMode,
   output logic [TAG_W-1:0] OutTag
);

   localparam int unsigned IMM_W  = 16;
   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] MODE_SIGN   = 2'd0;
   localparam logic [1:0] MODE_ZERO   = 2'd1;
   localparam logic [1:0] MODE_LUI    = 2'd2;
   localparam logic [1:0] MODE_BRANCH = 2'd3;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] imm;
      logic [1:0]        mode;
      logic [TAG_W-1:0]  tag;
   } entry_t;

   state_t            r_state;
   state_t            w_state_nxt;
   entry_t            r_main;
   entry_t            r_skid;
   entry_t            w_main_nxt;
   entry_t            w_skid_nxt;
   entry_t            w_new;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic [5:0]        w_opcode;
   logic [IMM_W-1:0]  w_imm;
   logic [1:0]        w_mode;
   logic [DATA_W-1:0] w_ext;
   logic              w_unused_rs_rt;

   assign w_opcode       = Instruction[31:26];
   assign w_imm          = Instruction[15:0];
   assign w_unused_rs_rt = ^Instruction[25:16];

   // Opcode decode and extension; only the extended result is ever stored.
   always_comb begin
      w_mode = MODE_SIGN;
      case (w_opcode)
`ifdef IMM_ZERO_EXTEND_EN
         6'h0C, 6'h0D, 6'h0E:                 w_mode = MODE_ZERO;
`endif
         6'h0F:                               w_mode = MODE_LUI;
         6'h01, 6'h04, 6'h05, 6'h06, 6'h07:   w_mode = MODE_BRANCH;
         default:                             w_mode = MODE_SIGN;
      endcase

      w_ext = {{16{w_imm[15]}}, w_imm};
      case (w_mode)
         MODE_ZERO:   w_ext = {16'h0000, w_imm};
         MODE_LUI:    w_ext = {w_imm, 16'h0000};
         MODE_BRANCH: w_ext = {{14{w_imm[15]}}, w_imm, 2'b00};
         default:     w_ext = {{16{w_imm[15]}}, w_imm};
      endcase

      w_new.imm  = w_ext;
      w_new.mode = w_mode;
      w_new.tag  = InTag;
   end

   assign w_in_xfer  = InValid && r_in_ready;
   assign w_out_xfer = r_out_valid && OutReady;

   // Next-state and buffer update; flush wins over every other event.
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;

      if (Flush) begin
         w_state_nxt = ST_EMPTY;
         w_main_nxt  = '0;
         w_skid_nxt  = '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_xfer) begin
                  w_state_nxt = ST_ONE;
                  w_main_nxt  = w_new;
               end
            end
            ST_ONE: begin
               case ({w_in_xfer, w_out_xfer})
                  2'b10: begin
                     w_state_nxt = ST_FULL;
                     w_skid_nxt  = w_new;
                  end
                  2'b01: begin
                     w_state_nxt = ST_EMPTY;
                     w_main_nxt  = '0;
                  end
                  2'b11: begin
                     w_main_nxt  = w_new;
                  end
                  default: begin
                     w_state_nxt = ST_ONE;
                  end
               endcase
            end
            ST_FULL: begin
               if (w_out_xfer) begin
                  w_state_nxt = ST_ONE;
                  w_main_nxt  = r_skid;
                  w_skid_nxt  = '0;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
               w_main_nxt  = '0;
               w_skid_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= ST_EMPTY;
         r_main      <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_main      <= w_main_nxt;
         r_skid      <= w_skid_nxt;
         r_in_ready  <= (w_state_nxt != ST_FULL);
         r_out_valid <= (w_state_nxt != ST_EMPTY);
      end
   end

   assign InReady  = r_in_ready;
   assign OutValid = r_out_valid;
   assign ImmOut   = r_main.imm;
   assign ExtMode  = r_main.mode;
   assign OutTag   = r_main.tag;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: decode table, backpressure, flush and async reset.
module tb_imm_extend_stage;

   localparam int unsigned TAG_W = 5;

`ifdef IMM_ZERO_EXTEND_EN
   localparam bit         ZEXT = 1'b1;
`else
   localparam bit         ZEXT = 1'b0;
`endif

   logic             Clk;
   logic             Reset;
   logic             InValid;
   logic             InReady;
   logic [31:0]      Instruction;
   logic [TAG_W-1:0] InTag;
   logic             Flush;
   logic             OutValid;
   logic             OutReady;
   logic [31:0]      ImmOut;
   logic [1:0]       ExtMode;
   logic [TAG_W-1:0] OutTag;

   int n_checks = 0;
   int n_fail   = 0;

   imm_extend_stage #(.TAG_W(TAG_W)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .InValid    (InValid),
      .InReady    (InReady),
      .Instruction(Instruction),
      .InTag      (InTag),
      .Flush      (Flush),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .ImmOut     (ImmOut),
      .ExtMode    (ExtMode),
      .OutTag     (OutTag)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [31:0]      instr;
      logic [TAG_W-1:0] tag;
      logic [31:0]      imm;
      logic [1:0]       mode;
   } vec_t;

   vec_t vecs[17];

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
      return {op, 5'd3, 5'd7, imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic v, input logic [31:0] imm,
                          input logic [1:0] mode, input logic [TAG_W-1:0] tag);
      chk({name, ".valid"}, 32'(OutValid), 32'(v));
      chk({name, ".imm"},   ImmOut,        imm);
      chk({name, ".mode"},  32'(ExtMode),  32'(mode));
      chk({name, ".tag"},   32'(OutTag),   32'(tag));
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [TAG_W-1:0] tag);
      InValid     = v;
      Instruction = instr;
      InTag       = tag;
   endtask

   initial begin
      vecs[0]  = '{mk(6'h08, 16'h8001), 5'd3,  32'hFFFF8001, 2'd0};
      vecs[1]  = '{mk(6'h08, 16'h7FFF), 5'd4,  32'h00007FFF, 2'd0};
      vecs[2]  = '{mk(6'h0D, 16'hF00F), 5'd5,  ZEXT ? 32'h0000F00F : 32'hFFFFF00F, ZEXT ? 2'd1 : 2'd0};
      vecs[3]  = '{mk(6'h0C, 16'h8000), 5'd6,  ZEXT ? 32'h00008000 : 32'hFFFF8000, ZEXT ? 2'd1 : 2'd0};
      vecs[4]  = '{mk(6'h0E, 16'h1234), 5'd7,  32'h00001234, ZEXT ? 2'd1 : 2'd0};
      vecs[5]  = '{mk(6'h0F, 16'h1234), 5'd8,  32'h12340000, 2'd2};
      vecs[6]  = '{mk(6'h0F, 16'hFFFF), 5'd9,  32'hFFFF0000, 2'd2};
      vecs[7]  = '{mk(6'h04, 16'hFFFE), 5'd10, 32'hFFFFFFF8, 2'd3};
      vecs[8]  = '{mk(6'h05, 16'h0001), 5'd11, 32'h00000004, 2'd3};
      vecs[9]  = '{mk(6'h06, 16'h8000), 5'd12, 32'hFFFE0000, 2'd3};
      vecs[10] = '{mk(6'h07, 16'h7FFF), 5'd13, 32'h0001FFFC, 2'd3};
      vecs[11] = '{mk(6'h01, 16'h0010), 5'd14, 32'h00000040, 2'd3};
      vecs[12] = '{mk(6'h00, 16'h8020), 5'd15, 32'hFFFF8020, 2'd0};
      vecs[13] = '{mk(6'h23, 16'hFFFC), 5'd16, 32'hFFFFFFFC, 2'd0};
      vecs[14] = '{mk(6'h02, 16'h4000), 5'd17, 32'h00004000, 2'd0};
      vecs[15] = '{mk(6'h10, 16'h9000), 5'd30, 32'hFFFF9000, 2'd0};
      vecs[16] = '{mk(6'h0B, 16'hC000), 5'd31, 32'hFFFFC000, 2'd0};

      Reset    = 1'b1;
      Flush    = 1'b0;
      OutReady = 1'b1;
      drive(1'b0, 32'h0, '0);

      step();
      chk("reset.in_ready", 32'(InReady), 32'd0);
      chk_out("reset", 1'b0, 32'h0, 2'd0, '0);
      Reset = 1'b0;
      step();
      chk("post_reset.in_ready", 32'(InReady), 32'd1);

      // Streaming at full rate: each output appears one cycle after its acceptance.
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, vecs[i].instr, vecs[i].tag);
         step();
         chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].imm, vecs[i].mode, vecs[i].tag);
         chk($sformatf("vec%0d.in_ready", i), 32'(InReady), 32'd1);
      end
      drive(1'b0, 32'h0, '0);
      step();
      chk_out("drain_empty", 1'b0, 32'h0, 2'd0, '0);

      // Backpressure: A, B fill the buffer, C waits, then all drain in order.
      OutReady = 1'b0;
      drive(1'b1, mk(6'h08, 16'h000A), 5'd1);
      step();
      chk_out("bp.A0", 1'b1, 32'h0000000A, 2'd0, 5'd1);
      chk("bp.ir0", 32'(InReady), 32'd1);
      drive(1'b1, mk(6'h0F, 16'h000B), 5'd2);
      step();
      chk_out("bp.A1", 1'b1, 32'h0000000A, 2'd0, 5'd1);
      chk("bp.ir1", 32'(InReady), 32'd0);
      drive(1'b1, mk(6'h04, 16'h000C), 5'd3);
      step();
      chk_out("bp.A2", 1'b1, 32'h0000000A, 2'd0, 5'd1);
      chk("bp.ir2", 32'(InReady), 32'd0);
      step();
      chk_out("bp.A3", 1'b1, 32'h0000000A, 2'd0, 5'd1);
      chk("bp.ir3", 32'(InReady), 32'd0);
      OutReady = 1'b1;
      step();
      chk_out("bp.B", 1'b1, 32'h000B0000, 2'd2, 5'd2);
      chk("bp.ir4", 32'(InReady), 32'd1);
      step();
      chk_out("bp.C", 1'b1, 32'h00000030, 2'd3, 5'd3);
      drive(1'b0, 32'h0, '0);
      step();
      chk_out("bp.end", 1'b0, 32'h0, 2'd0, '0);

      // Flush in FULL with a concurrent offer: everything is discarded.
      OutReady = 1'b0;
      drive(1'b1, mk(6'h08, 16'h0D0D), 5'd4);
      step();
      drive(1'b1, mk(6'h08, 16'h0E0E), 5'd5);
      step();
      chk("fl.full_ir", 32'(InReady), 32'd0);
      Flush = 1'b1;
      drive(1'b1, mk(6'h08, 16'h0F0F), 5'd6);
      step();
      chk_out("fl.after", 1'b0, 32'h0, 2'd0, '0);
      chk("fl.ir", 32'(InReady), 32'd1);
      Flush = 1'b0;
      drive(1'b0, 32'h0, '0);
      OutReady = 1'b1;
      step();
      chk_out("fl.gone", 1'b0, 32'h0, 2'd0, '0);

      // Flush while empty drops the input even though InReady is 1.
      Flush = 1'b1;
      drive(1'b1, mk(6'h08, 16'h1111), 5'd7);
      step();
      Flush = 1'b0;
      drive(1'b0, 32'h0, '0);
      chk_out("fl.empty_drop", 1'b0, 32'h0, 2'd0, '0);
      step();
      chk_out("fl.empty_gone", 1'b0, 32'h0, 2'd0, '0);

      // Asynchronous reset mid-stream, then resume.
      OutReady = 1'b0;
      drive(1'b1, mk(6'h08, 16'h2222), 5'd8);
      step();
      drive(1'b1, mk(6'h08, 16'h3333), 5'd9);
      step();
      #2;
      Reset = 1'b1;
      #1;
      chk_out("rst.async", 1'b0, 32'h0, 2'd0, '0);
      chk("rst.async_ir", 32'(InReady), 32'd0);
      @(posedge Clk);
      #1;
      Reset    = 1'b0;
      OutReady = 1'b1;
      drive(1'b1, mk(6'h0F, 16'h4444), 5'd10);
      step();
      chk_out("rst.first_edge", 1'b0, 32'h0, 2'd0, '0);
      chk("rst.ir_back", 32'(InReady), 32'd1);
      step();
      chk_out("rst.resume", 1'b1, 32'h44440000, 2'd2, 5'd10);
      drive(1'b0, 32'h0, '0);
      step();
      chk_out("rst.end", 1'b0, 32'h0, 2'd0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_extend_stage.md
IMM_EXTEND_STAGE -- requirements
Module: imm_extend_stage

Interface
REQ-001 The block SHALL have parameter TAG_W, default 5, giving the width of the sideband tag carried alongside each instruction.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port InValid, input, 1, meaning Instruction/InTag carry a valid instruction.
REQ-005 The block SHALL have port InReady, output, 1, meaning the block accepts the input this cycle.
REQ-006 The block SHALL have port Instruction, input, 32, the fetched MIPS instruction word.
REQ-007 The block SHALL have port InTag, input, TAG_W, the sideband tag, carried unmodified.
REQ-008 The block SHALL have port Flush, input, 1, meaning discard all held entries.
REQ-009 The block SHALL have port OutValid, output, 1, meaning ImmOut/ExtMode/OutTag are valid.
REQ-010 The block SHALL have port OutReady, input, 1, meaning the downstream consumer accepts the output.
REQ-011 The block SHALL have port ImmOut, output, 32, the extended immediate.
REQ-012 The block SHALL have port ExtMode, output, 2, the applied mode: 0 SIGN, 1 ZERO, 2 LUI, 3 BRANCH.
REQ-013 The block SHALL have port OutTag, output, TAG_W, the tag of the presented entry.

Function
REQ-014 The block SHALL decode opcode Instruction[31:26] as follows: 0x0C/0x0D/0x0E -> ZERO; 0x0F -> LUI; 0x01, 0x04-0x07 -> BRANCH; all others -> SIGN.
REQ-015 The block SHALL compute ImmOut as follows: SIGN {16{imm[15]},imm}; ZERO {16'h0000,imm}; LUI {imm,16'h0000}; BRANCH {{14{imm[15]}},imm,2'b00}, where imm = Instruction[15:0].
REQ-016 The block SHALL compute the extension at acceptance time and store the 32-bit result, the mode and the tag, never the raw instruction.
REQ-017 The block SHALL hold entries in a 2-entry buffer (main + skid) with state machine EMPTY, ONE, FULL.
REQ-018 An input transfer SHALL occur when InValid && InReady; an output transfer SHALL occur when OutValid && OutReady.
REQ-019 InReady SHALL be a registered signal, equal to 1 in EMPTY and ONE and 0 in FULL.
REQ-020 OutValid SHALL be 1 in ONE and FULL and 0 in EMPTY; the outputs SHALL present the oldest entry.
REQ-021 The state SHALL transition as follows: EMPTY+in -> ONE; ONE+in without out -> FULL; ONE+out without in -> EMPTY; ONE+in+out -> ONE; FULL+out -> ONE. All other combinations hold the state.
REQ-022 Latency SHALL be 1 cycle: an instruction accepted at edge N is presented at OutValid after edge N.
REQ-023 With sustained InValid and OutReady, throughput SHALL be one instruction per cycle with no bubbles.
REQ-024 Outputs SHALL remain stable while OutValid && !OutReady.
REQ-025 When the state is FULL and OutReady rises, the skid entry SHALL move to main on the same edge, and InReady SHALL return to 1 the following cycle.
REQ-026 Flush SHALL take priority over all other events: the next state is EMPTY and the input offered in that cycle is dropped, even if InReady was 1.
REQ-027 Entries in the EMPTY state SHALL drive ImmOut, ExtMode and OutTag to zero.

Reset
REQ-028 While Reset is asserted, the state SHALL be EMPTY, InReady 0, OutValid 0, ImmOut 32'h0, ExtMode 0 and OutTag 0.
REQ-029 InReady SHALL become 1 on the first Clk edge after Reset deasserts.
REQ-030 Reset asserted mid-transfer SHALL discard all entries immediately, with no partial output.

Configuration
REQ-031 The block SHALL support the macro IMM_ZERO_EXTEND_EN: when defined, opcodes 0x0C/0x0D/0x0E use ZERO mode as in REQ-014.
REQ-032 When IMM_ZERO_EXTEND_EN is not defined, opcodes 0x0C/0x0D/0x0E SHALL use SIGN mode (ExtMode 0), and ExtMode SHALL never be 1.

Verification
REQ-033 Scenario, addi: with OutReady=1, addi imm 16'h8001, tag 3 -> the next cycle gives ImmOut 32'hFFFF8001, ExtMode 0, OutTag 3.
REQ-034 Scenario, ori with macro on: ori imm 16'hF00F -> ImmOut 32'h0000F00F, ExtMode 1. With the macro off -> 32'hFFFFF00F, ExtMode 0.
REQ-035 Scenario, lui and beq: lui imm 16'h1234 -> 32'h12340000, ExtMode 2. beq imm 16'hFFFE -> 32'hFFFFFFF8, ExtMode 3.
REQ-036 Scenario, backpressure: OutReady=0 while instructions A, B, C are offered -> A and B are accepted, InReady=0 from the cycle after B, and C is held. OutReady=1 -> A, B, C emerge in order with no loss or duplication.
REQ-037 Scenario, flush: Flush is asserted in FULL together with InValid -> the next cycle gives OutValid 0, InReady 1, and the flushed entries never appear.
REQ-038 Scenario, reset: Reset pulses mid-stream with asynchronous timing -> outputs are zero immediately, and streaming resumes from the first post-reset acceptance.
